// File: rtl/adder_32bit.sv
// 32-bit two-level carry-lookahead adder with registered SUM/Overflow.
// Define ADDER32_COUT_EN to expose the registered unsigned carry-out COUT.
module adder_32bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        C0,
    output logic [31:0] SUM,
    output logic        Overflow
`ifdef ADDER32_COUT_EN
    ,
    output logic        COUT
`endif
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [8:0]  grp_c;

    logic [31:0] sum_d;
    logic [31:0] sum_q;
    logic        ovf_d;
    logic        ovf_q;
    logic        c32;

    always_comb begin
        g     = A & B;
        p     = A ^ B;
        grp_g = '0;
        grp_p = '0;
        for (int k = 0; k < 8; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
    end

    // Each group carry is a flat sum of products over G/P, not a chain.
    always_comb begin
        logic pp;
        logic term;
        pp       = 1'b1;
        term     = 1'b0;
        grp_c    = '0;
        grp_c[0] = C0;
        for (int k = 1; k <= 8; k++) begin
            pp   = 1'b1;
            term = 1'b0;
            for (int j = k - 1; j >= 0; j--) begin
                term = term | (grp_g[j] & pp);
                pp   = pp & grp_p[j];
            end
            grp_c[k] = term | (C0 & pp);
        end
    end

    always_comb begin
        logic ci;
        ci = 1'b0;
        c  = '0;
        for (int k = 0; k < 8; k++) begin
            ci         = grp_c[k];
            c[4*k]     = ci;
            c[4*k+1]   = g[4*k] | (p[4*k] & ci);
            c[4*k+2]   = g[4*k+1]
                       | (p[4*k+1] & g[4*k])
                       | (p[4*k+1] & p[4*k] & ci);
            c[4*k+3]   = g[4*k+2]
                       | (p[4*k+2] & g[4*k+1])
                       | (p[4*k+2] & p[4*k+1] & g[4*k])
                       | (p[4*k+2] & p[4*k+1] & p[4*k] & ci);
        end
        c32   = grp_c[8];
        sum_d = p ^ c;
        ovf_d = c[31] ^ c32;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            ovf_q <= ovf_d;
        end
    end

    assign SUM      = sum_q;
    assign Overflow = ovf_q;

`ifdef ADDER32_COUT_EN
    logic cout_d;
    logic cout_q;

    always_comb begin
        cout_d = c32;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cout_q <= 1'b0;
        end else begin
            cout_q <= cout_d;
        end
    end

    assign COUT = cout_q;
`endif

endmodule

// File: tb/tb_adder_32bit.sv
// Scoreboard bench for adder_32bit: directed corners plus random regression
// with random mid-stream resets, checked against a 33-bit arithmetic model.
module tb_adder_32bit;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic        C0;
    logic [31:0] SUM;
    logic        Overflow;
`ifdef ADDER32_COUT_EN
    logic        COUT;
`endif

    adder_32bit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .C0       (C0),
        .SUM      (SUM),
        .Overflow (Overflow)
`ifdef ADDER32_COUT_EN
        ,
        .COUT     (COUT)
`endif
    );

    typedef struct packed {
        logic [31:0] sum;
        logic        ovf;
        logic        cout;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    bit   have_last;
    bit   drv_done;
    int   tests;
    int   fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic rst, input logic [31:0] a,
                                   input logic [31:0] b, input logic ci);
        exp_t      e;
        bit [32:0] full;
        full = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        e.sum  = full[31:0];
        e.cout = full[32];
        e.ovf  = (a[31] == b[31]) && (full[31] != a[31]);
        if (!rst) e = '0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req,
                     $time);
        end
    endtask

    task automatic drive(input logic rst, input logic [31:0] a,
                         input logic [31:0] b, input logic ci);
        @(negedge clk);
        rst_n = rst;
        A     = a;
        B     = b;
        C0    = ci;
        exp_q.push_back(model(rst, a, b, ci));
        #1;
        if (have_last) begin
            chk("hold_sum", SUM, last_exp.sum);
            chk("hold_ovf", {31'd0, Overflow}, {31'd0, last_exp.ovf});
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sum", SUM, e.sum);
                chk("ovf", {31'd0, Overflow}, {31'd0, e.ovf});
`ifdef ADDER32_COUT_EN
                chk("cout", {31'd0, COUT}, {31'd0, e.cout});
`endif
                last_exp  = e;
                have_last = 1'b1;
            end
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int budget;
        tests     = 0;
        fails     = 0;
        have_last = 1'b0;
        drv_done  = 1'b0;
        rst_n     = 1'b0;
        A         = 32'hFFFF_FFFF;
        B         = 32'd1;
        C0        = 1'b0;

        drive(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        drive(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        drive(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);

        drive(1'b1, 32'd0, 32'd0, 1'b0);
        drive(1'b1, 32'd2, 32'd0, 1'b0);
        drive(1'b1, 32'd2, 32'd3, 1'b0);
        drive(1'b1, 32'd2, 32'd3, 1'b1);

        drive(1'b1, 32'h7FFF_FFFF, 32'd0, 1'b1);
        drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        drive(1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1);
        drive(1'b1, 32'h0000_FFFF, 32'd1, 1'b0);

        drive(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1);
        drive(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            drive(($urandom_range(0, 49) != 0), pick(), pick(),
                  1'($urandom_range(0, 1)));
        end

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results pending, expected 0",
                     exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
